clk_div_gen: RTL and testbench

Multi-channel, runtime-programmable clock-enable and divided-clock generator for the single-clock display/peripheral domain. It generalises the fixed-ratio divider. Each of `CHANNELS` independent channels divides `clk` by a programmable integer `D` and produces two registered outputs: a one-cycle `tick` enable and a near-50 % `clk_out` square wave. Divisor changes are glitch-free because each new divisor is applied only at a period boundary. A shared `sync` input phase-aligns all channels.

---
 rtl/clk_div_gen_pkg.sv | 18 +
 rtl/clk_div_chan.sv | 102 ++++++++++
 rtl/clk_div_gen.sv | 48 ++++
 tb/tb_clk_div_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_gen_pkg.sv
// Shared types, limits and helpers for the clk_div_gen divider channels.
package clk_div_gen_pkg;

    localparam int unsigned MAX_CHANNELS = 16;
    localparam int unsigned MAX_WIDTH    = 32;

    typedef struct packed {
        logic pending;
        logic tick;
        logic clk_out;
    } chan_flags_t;

    // ceil(d/2) formed as (d>>1) + d[0]; cannot overflow for any d
    function automatic logic [MAX_WIDTH-1:0] half_ceil(input logic [MAX_WIDTH-1:0] d);
        return (d >> 1) + {{(MAX_WIDTH-1){1'b0}}, d[0]};
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: active/shadow divisor, period counter, tick and clk_out flops.
// Optional CLK_DIV_GEN_PHASE_EN adds a per-channel phase preset applied on sync.
module clk_div_chan
    import clk_div_gen_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned RESET_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    input  logic             enable,
    input  logic             sync,
`ifdef CLK_DIV_GEN_PHASE_EN
    input  logic [WIDTH-1:0] phase_in,
`endif
    output logic             tick,
    output logic             clk_out,
    output logic             pending
);

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] cnt;
        chan_flags_t      flags;
    } chan_state_t;

    chan_state_t      state_q;
    chan_state_t      state_n;
    logic [WIDTH-1:0] step;
    logic [MAX_WIDTH-1:0] hc;
    logic             running;
    logic             wrap;

    always_comb begin
        state_n            = state_q;
        state_n.flags.tick = 1'b0;

        // >= rather than == keeps a held count that exceeds a freshly loaded divisor in range
        step    = (state_q.cnt >= state_q.d - WIDTH'(1)) ? '0 : state_q.cnt + WIDTH'(1);
        hc      = half_ceil(MAX_WIDTH'(state_q.d));
        running = enable && (state_q.d != '0);
        wrap    = running && (step == '0);

        if (sync) begin
            if (div_load) begin
                state_n.d = div_in;
                state_n.s = div_in;
            end else if (state_q.flags.pending) begin
                state_n.d = state_q.s;
            end
            state_n.cnt           = '0;
`ifdef CLK_DIV_GEN_PHASE_EN
            if (phase_in < state_n.d) begin
                state_n.cnt = phase_in;
            end
`endif
            state_n.flags.pending = 1'b0;
            state_n.flags.clk_out = 1'b0;
        end else begin
            if (state_q.d == '0) begin
                state_n.cnt           = '0;
                state_n.flags.clk_out = 1'b0;
            end else if (enable) begin
                state_n.cnt           = step;
                state_n.flags.tick    = wrap;
                state_n.flags.clk_out = (step != '0) && (MAX_WIDTH'(step) <= hc);
            end

            if (div_load) begin
                state_n.s = div_in;
                if (wrap || !running) begin
                    state_n.d             = div_in;
                    state_n.flags.pending = 1'b0;
                end else begin
                    state_n.flags.pending = 1'b1;
                end
            end else if (wrap && state_q.flags.pending) begin
                state_n.d             = state_q.s;
                state_n.flags.pending = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q.d     <= WIDTH'(RESET_DIV);
            state_q.s     <= WIDTH'(RESET_DIV);
            state_q.cnt   <= '0;
            state_q.flags <= '0;
        end else begin
            state_q <= state_n;
        end
    end

    assign tick    = state_q.flags.tick;
    assign clk_out = state_q.flags.clk_out;
    assign pending = state_q.flags.pending;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock-enable / divided-clock generator.
// Define CLK_DIV_GEN_PHASE_EN to add the phase_in port for per-channel sync offsets.
module clk_div_gen
    import clk_div_gen_pkg::*;
#(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned RESET_DIV = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] div_in,
    input  logic [CHANNELS-1:0]       div_load,
    input  logic [CHANNELS-1:0]       enable,
    input  logic                      sync,
`ifdef CLK_DIV_GEN_PHASE_EN
    input  logic [CHANNELS*WIDTH-1:0] phase_in,
`endif
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       clk_out,
    output logic [CHANNELS-1:0]       pending
);

    if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS || WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_cfg
        $error("clk_div_gen: unsupported CHANNELS/WIDTH");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        clk_div_chan #(
            .WIDTH     (WIDTH),
            .RESET_DIV (RESET_DIV)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .div_in   (div_in[i*WIDTH +: WIDTH]),
            .div_load (div_load[i]),
            .enable   (enable[i]),
            .sync     (sync),
`ifdef CLK_DIV_GEN_PHASE_EN
            .phase_in (phase_in[i*WIDTH +: WIDTH]),
`endif
            .tick     (tick[i]),
            .clk_out  (clk_out[i]),
            .pending  (pending[i])
        );
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed, table-driven self-checking bench for clk_div_gen (4 channels, 16-bit divisors).
module tb_clk_div_gen;

    localparam int unsigned CH = 4;
    localparam int unsigned W  = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH*W-1:0] div_in;
    logic [CH-1:0]   div_load;
    logic [CH-1:0]   enable;
    logic            sync;
`ifdef CLK_DIV_GEN_PHASE_EN
    logic [CH*W-1:0] phase_in;
`endif
    logic [CH-1:0]   tick;
    logic [CH-1:0]   clk_out;
    logic [CH-1:0]   pending;

    int n_vec = 0;
    int n_err = 0;

    clk_div_gen #(
        .CHANNELS  (CH),
        .WIDTH     (W),
        .RESET_DIV (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .div_in   (div_in),
        .div_load (div_load),
        .enable   (enable),
        .sync     (sync),
`ifdef CLK_DIV_GEN_PHASE_EN
        .phase_in (phase_in),
`endif
        .tick     (tick),
        .clk_out  (clk_out),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH-1:0]   load;
        logic [CH*W-1:0] div;
        logic [CH-1:0]   en;
        logic [CH-1:0]   chk;
        logic [CH-1:0]   exp_tick;
        logic [CH-1:0]   exp_clk;
        logic [CH-1:0]   exp_pend;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [CH*W-1:0] dv4(input int unsigned a, b, c, d);
        return {W'(d), W'(c), W'(b), W'(a)};
    endfunction

    function automatic vec_t mk(input logic [CH-1:0] load, input logic [CH*W-1:0] div,
                                input logic [CH-1:0] en, input logic [CH-1:0] chk,
                                input logic [CH-1:0] t, input logic [CH-1:0] c,
                                input logic [CH-1:0] p);
        vec_t v;
        v.load = load; v.div = div; v.en = en; v.chk = chk;
        v.exp_tick = t; v.exp_clk = c; v.exp_pend = p;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [CH-1:0] act, input logic [CH-1:0] exp,
                       input logic [CH-1:0] m);
        n_vec++;
        if ((act & m) !== (exp & m)) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (mask %b)", nm, act, exp, m);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned dvs [CH];
        logic [CH-1:0] et, ec;
        int unsigned ph;

        rst = 1'b1; div_in = '0; div_load = '0; enable = '0; sync = 1'b0;
`ifdef CLK_DIV_GEN_PHASE_EN
        phase_in = '0;
`endif
        step();
        div_load = '1; enable = '1; sync = 1'b1; div_in = dv4(9, 9, 9, 9);
        step();
        cmp("reset_tick", tick, '0, '1);
        cmp("reset_clk", clk_out, '0, '1);
        cmp("reset_pend", pending, '0, '1);
        rst = 1'b0; div_load = '0; enable = '0; sync = 1'b0;

        // ch0 D=4, ch1 D=5 then load 2 mid-period
        tbl.push_back(mk(4'b0011, dv4(4, 5, 0, 0), 4'b0000, 4'b0011, 4'b00, 4'b00, 4'b00));
        tbl.push_back(mk(4'b0000, '0,             4'b0011, 4'b0011, 4'b00, 4'b11, 4'b00));
        tbl.push_back(mk(4'b0000, '0,             4'b0011, 4'b0011, 4'b00, 4'b11, 4'b00));
        tbl.push_back(mk(4'b0010, dv4(0, 2, 0, 0), 4'b0011, 4'b0011, 4'b00, 4'b10, 4'b10));
        tbl.push_back(mk(4'b0000, '0,             4'b0011, 4'b0011, 4'b01, 4'b00, 4'b10));
        tbl.push_back(mk(4'b0000, '0,             4'b0011, 4'b0011, 4'b10, 4'b01, 4'b00));
        tbl.push_back(mk(4'b0000, '0,             4'b0011, 4'b0011, 4'b00, 4'b11, 4'b00));
        tbl.push_back(mk(4'b0000, '0,             4'b0011, 4'b0011, 4'b10, 4'b00, 4'b00));
        tbl.push_back(mk(4'b0000, '0,             4'b0011, 4'b0011, 4'b01, 4'b10, 4'b00));
        tbl.push_back(mk(4'b0000, '0,             4'b0011, 4'b0011, 4'b10, 4'b01, 4'b00));
        tbl.push_back(mk(4'b0000, '0,             4'b0011, 4'b0011, 4'b00, 4'b11, 4'b00));
        tbl.push_back(mk(4'b0000, '0,             4'b0011, 4'b0011, 4'b10, 4'b00, 4'b00));
        tbl.push_back(mk(4'b0000, '0,             4'b0011, 4'b0011, 4'b01, 4'b10, 4'b00));
        // ch2 D=6, enable dropped for 3 cycles after E2
        tbl.push_back(mk(4'b0100, dv4(0, 0, 6, 0), 4'b0000, 4'b0100, 4'b0, 4'b0000, 4'b0));
        tbl.push_back(mk(4'b0000, '0,             4'b0100, 4'b0100, 4'b0, 4'b0100, 4'b0));
        tbl.push_back(mk(4'b0000, '0,             4'b0100, 4'b0100, 4'b0, 4'b0100, 4'b0));
        tbl.push_back(mk(4'b0000, '0,             4'b0000, 4'b0100, 4'b0, 4'b0100, 4'b0));
        tbl.push_back(mk(4'b0000, '0,             4'b0000, 4'b0100, 4'b0, 4'b0100, 4'b0));
        tbl.push_back(mk(4'b0000, '0,             4'b0000, 4'b0100, 4'b0, 4'b0100, 4'b0));
        tbl.push_back(mk(4'b0000, '0,             4'b0100, 4'b0100, 4'b0, 4'b0100, 4'b0));
        tbl.push_back(mk(4'b0000, '0,             4'b0100, 4'b0100, 4'b0, 4'b0000, 4'b0));
        tbl.push_back(mk(4'b0000, '0,             4'b0100, 4'b0100, 4'b0, 4'b0000, 4'b0));
        tbl.push_back(mk(4'b0000, '0,             4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0));
        tbl.push_back(mk(4'b0000, '0,             4'b0100, 4'b0100, 4'b0, 4'b0100, 4'b0));
        // ch3 halted with D=0, then D=3 applied immediately
        tbl.push_back(mk(4'b1000, dv4(0, 0, 0, 0), 4'b0000, 4'b1000, 4'b0, 4'b0, 4'b0));
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(4'b0000, '0, 4'b1000, 4'b1000, 4'b0, 4'b0, 4'b0));
        tbl.push_back(mk(4'b1000, dv4(0, 0, 0, 3), 4'b1000, 4'b1000, 4'b0, 4'b0, 4'b0));
        tbl.push_back(mk(4'b0000, '0,             4'b1000, 4'b1000, 4'b0, 4'b1000, 4'b0));
        tbl.push_back(mk(4'b0000, '0,             4'b1000, 4'b1000, 4'b0, 4'b1000, 4'b0));
        tbl.push_back(mk(4'b0000, '0,             4'b1000, 4'b1000, 4'b1000, 4'b0, 4'b0));
        tbl.push_back(mk(4'b0000, '0,             4'b1000, 4'b1000, 4'b0, 4'b1000, 4'b0));
        // ch0 D=1, then a load on a wrap edge bypasses the shadow
        tbl.push_back(mk(4'b0001, dv4(1, 0, 0, 0), 4'b0000, 4'b0001, 4'b0, 4'b0, 4'b0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(4'b0000, '0, 4'b0001, 4'b0001, 4'b0001, 4'b0, 4'b0));
        tbl.push_back(mk(4'b0001, dv4(2, 0, 0, 0), 4'b0001, 4'b0001, 4'b0001, 4'b0, 4'b0));
        tbl.push_back(mk(4'b0000, '0,             4'b0001, 4'b0001, 4'b0, 4'b0001, 4'b0));
        tbl.push_back(mk(4'b0000, '0,             4'b0001, 4'b0001, 4'b0001, 4'b0, 4'b0));

        for (int i = 0; i < tbl.size(); i++) begin
            div_load = tbl[i].load;
            div_in   = tbl[i].div;
            enable   = tbl[i].en;
            step();
            cmp($sformatf("vec%0d_tick", i), tick, tbl[i].exp_tick, tbl[i].chk);
            cmp($sformatf("vec%0d_clk", i), clk_out, tbl[i].exp_clk, tbl[i].chk);
            cmp($sformatf("vec%0d_pend", i), pending, tbl[i].exp_pend, tbl[i].chk);
        end
        div_load = '0; div_in = '0;

        // mixed divisors 2,3,4,7 realigned by sync; ch3's pending 7 is applied by the sync
        dvs = '{2, 3, 4, 7};
        div_load = '1; div_in = dv4(2, 3, 4, 5); enable = '0;
        step();
        div_load = '0; enable = '1;
        repeat (5) step();
        div_load = 4'b1000; div_in = dv4(0, 0, 0, 7);
        step();
        cmp("pre_sync_pend", pending, 4'b1000, '1);
        div_load = '0; sync = 1'b1;
        step();
        cmp("sync_tick", tick, '0, '1);
        cmp("sync_clk", clk_out, '0, '1);
        cmp("sync_pend", pending, '0, '1);
        sync = 1'b0;
        for (int k = 1; k <= 84; k++) begin
            for (int i = 0; i < CH; i++) begin
                ph    = k % dvs[i];
                et[i] = (ph == 0);
                ec[i] = (ph != 0) && (ph <= (dvs[i] + 1) / 2);
            end
            step();
            cmp($sformatf("lcm_k%0d_tick", k), tick, et, '1);
            cmp($sformatf("lcm_k%0d_clk", k), clk_out, ec, '1);
        end

        // reset mid-period overrides sync, load and enable
        rst = 1'b1; sync = 1'b1; div_load = '1; div_in = dv4(5, 5, 5, 5); enable = '1;
        step();
        cmp("midrst_tick", tick, '0, '1);
        cmp("midrst_clk", clk_out, '0, '1);
        cmp("midrst_pend", pending, '0, '1);
        rst = 1'b0; sync = 1'b0; div_load = '0; enable = 4'b0001;
        step();
        cmp("rstdiv_e1_tick", tick, 4'b0000, '1);
        cmp("rstdiv_e1_clk", clk_out, 4'b0001, '1);
        step();
        cmp("rstdiv_e2_tick", tick, 4'b0001, '1);
        cmp("rstdiv_e2_clk", clk_out, 4'b0000, '1);

`ifdef CLK_DIV_GEN_PHASE_EN
        div_load = 4'b0011; div_in = dv4(4, 4, 0, 0); enable = '0;
        phase_in = dv4(2, 9, 0, 0);
        step();
        div_load = '0; enable = 4'b0011; sync = 1'b1;
        step();
        cmp("phase_sync_tick", tick, '0, 4'b0011);
        sync = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            et = (k == 2) ? 4'b0001 : (k == 4) ? 4'b0010 : 4'b0000;
            step();
            cmp($sformatf("phase_k%0d_tick", k), tick, et, 4'b0011);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
